// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - decode stage feeding the ext immediate extender
// Opcode decode on accept, 2-entry skid buffer of decoded fields, wrapping pop counter.
module imm_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_EOp,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  output logic [15:0] out_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  eop;
    logic [31:0] pc;
    logic        illegal;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  entry_t      dec_entry;
  logic        in_ready_q, in_ready_d;
  logic [15:0] count_q, count_d;
  logic        push, pop;
  logic        unused_rs_rt;

  // rs/rt fields play no part in immediate extension
  assign unused_rs_rt = ^in_instr[25:16];

  always_comb begin
    dec_entry.imm     = in_instr[15:0];
    dec_entry.eop     = 2'b00;
    dec_entry.pc      = in_pc;
    dec_entry.illegal = 1'b0;
    case (in_instr[31:26])
      6'b001001, 6'b001010, 6'b100011, 6'b101011: dec_entry.eop = 2'b00;
      6'b001100, 6'b001101:                       dec_entry.eop = 2'b01;
      6'b001111:                                  dec_entry.eop = 2'b10;
      6'b000100, 6'b000101:                       dec_entry.eop = 2'b11;
      6'b000000:                                  dec_entry.imm = 16'h0000;
      default:                                    dec_entry.illegal = 1'b1;
    endcase
  end

  assign push = in_valid & in_ready_q;
  assign pop  = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = pop ? count_q + 16'd1 : count_q;
    // A pop during flush is still a completed handshake, so count_d ignores flush
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = dec_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = dec_entry;
          end else if (push) begin
            tail_d  = dec_entry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      count_q    <= count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_imm     = head_q.imm;
  assign out_EOp     = head_q.eop;
  assign out_pc      = head_q.pc;
  assign out_illegal = head_q.illegal;
  assign out_count   = count_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - scoreboard bench for imm_decode_stage
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_illegal;
  logic [15:0] out_imm, out_count;
  logic [1:0]  out_EOp;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  imm_decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_EOp(out_EOp),
    .out_pc(out_pc), .out_illegal(out_illegal), .out_count(out_count)
  );

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  eop;
    logic [31:0] pc;
    logic        ill;
  } ent_t;

  ent_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_count = 16'd0;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t model(input logic [31:0] instr, input logic [31:0] pc);
    ent_t e;
    e.imm = instr[15:0];
    e.eop = 2'b00;
    e.pc  = pc;
    e.ill = 1'b0;
    case (instr[31:26])
      6'b001001, 6'b001010, 6'b100011, 6'b101011: e.eop = 2'b00;
      6'b001100, 6'b001101: e.eop = 2'b01;
      6'b001111:            e.eop = 2'b10;
      6'b000100, 6'b000101: e.eop = 2'b11;
      6'b000000:            e.imm = 16'h0000;
      default:              e.ill = 1'b1;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      chk("out_count", 64'(out_count), 64'(exp_count));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("head", 64'({out_imm, out_EOp, out_pc, out_illegal}), 64'(e));
        end
        exp_count = exp_count + 16'd1;
      end
      if (!reset) begin
        sb.delete();
        exp_count = 16'd0;
      end else if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back(model(in_instr, in_pc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_imm"}, 64'(out_imm), 64'(0));
    chk({tag, "_out_EOp"}, 64'(out_EOp), 64'(0));
    chk({tag, "_out_pc"}, 64'(out_pc), 64'(0));
    chk({tag, "_out_illegal"}, 64'(out_illegal), 64'(0));
    chk({tag, "_out_count"}, 64'(out_count), 64'(0));
  endtask

  logic [31:0] sweep [6] = '{32'h2421_FFFC, 32'h3021_00FF, 32'h3C01_1234,
                             32'h1022_FFFE, 32'h0000_0020, 32'hFC00_1234};

  initial begin
    int n;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) step();
    reset = 1'b1;
    mon_en = 1'b1;
    chk_reset_values("rst");

    // single ori
    step();
    in_valid = 1'b1; in_instr = 32'h3421_8006; in_pc = 32'h3000;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ori_valid", 64'(out_valid), 64'(1));
    chk("ori_imm", 64'(out_imm), 64'h8006);
    chk("ori_eop", 64'(out_EOp), 64'(2'b01));
    chk("ori_pc", 64'(out_pc), 64'h3000);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("ori_count", 64'(out_count), 64'(1));

    // opcode sweep
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = sweep[i]; in_pc = 32'h4000 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;

    // backpressure A,B,C
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h2400_0010 + 32'(i); in_pc = 32'h5000 + 32'(4 * i);
      step();
    end
    chk("bp_ready_low", 64'(in_ready), 64'(0));
    in_instr = 32'h3400_00CC; in_pc = 32'h5008;
    repeat (2) step();
    chk("bp_hold", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 10 && !in_ready; i++) step();
    step();
    in_valid = 1'b0;
    repeat (4) step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_count", 64'(out_count), 64'(10));

    // continuous push/pop
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc = 32'h6000 + 32'(4 * i);
      step();
      chk("stream_ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("stream_count", 64'(out_count), 64'(18));

    // flush while TWO
    step();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h3C00_0100 + 32'(i); in_pc = 32'h7000 + 32'(4 * i);
      step();
    end
    in_instr = 32'h3400_DEAD; in_pc = 32'h7008;
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush2_valid", 64'(out_valid), 64'(0));
    chk("flush2_ready", 64'(in_ready), 64'(1));
    chk("flush2_count", 64'(out_count), 64'(19));

    // flush while ONE: offered instruction must not be captured
    step();
    in_valid = 1'b1; in_instr = 32'h2400_0001; in_pc = 32'h7100;
    step();
    in_instr = 32'h3400_BEEF; in_pc = 32'h7104; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_valid", 64'(out_valid), 64'(0));

    // preload counter to 0xFFFF, then wrap
    step();
    n = int'(16'hFFFF - out_count);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc = 32'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("count_max", 64'(out_count), 64'hFFFF);
    in_valid = 1'b1; in_instr = 32'h3400_0001; in_pc = 32'h8000;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("count_wrap", 64'(out_count), 64'(0));

    // reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h3C00_0200 + 32'(i); in_pc = 32'h9000 + 32'(4 * i);
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1; in_valid = 1'b0;
    chk_reset_values("midrst");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Decode stage directly upstream of the `ext` immediate extender. Accepts 32-bit MIPS instructions with their PC over a valid/ready handshake, decodes the opcode into the `EOp` extension code, and holds the result in a 2-entry skid buffer. Its `out_imm`/`out_EOp` pair drives `ext.imm`/`ext.EOp` directly. A 16-bit issue counter supports debug.

## Interface
Parameters:
- none; all widths fixed by the MIPS encoding.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset: state clears on a rising `clk` edge while `reset`==0.
- `flush`  in  1  discards all buffered entries.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept; registered output.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of the instruction.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts head.
- `out_imm`  out  16  `instr[15:0]` of head; feeds `ext.imm`.
- `out_EOp`  out  2  extension code of head; feeds `ext.EOp`.
- `out_pc`  out  32  PC of head.
- `out_illegal`  out  1  head opcode unsupported.
- `out_count`  out  16  completed output handshakes, wrapping.

## Operation
- Decode happens on the accept path. The buffer stores decoded fields {imm, EOp, pc, illegal}, not raw instructions.
- Decode by opcode `instr[31:26]`:
  - 001001 addiu, 001010 slti, 100011 lw, 101011 sw -> EOp 00 (sign-extend).
  - 001100 andi, 001101 ori -> 01 (zero-extend).
  - 001111 lui -> 10 (imm<<16).
  - 000100 beq, 000101 bne -> 11 (sign-extend then <<2).
  - 000000 R-type -> EOp 00, imm forced to 0x0000, illegal 0.
  - Any other opcode -> EOp 00, imm passed through, illegal 1.
- Buffer states: EMPTY (0 entries), ONE, TWO. Let push = `in_valid & in_ready` and pop = `out_valid & out_ready`.
  - EMPTY: push -> ONE; otherwise stay.
  - ONE: push only -> TWO; pop only -> EMPTY; push and pop -> ONE (new entry becomes head).
  - TWO: pop -> ONE (second entry becomes head); push cannot occur.
- Outputs are combinational from the head register only: `out_valid` = (state != EMPTY).
- Strict FIFO ordering. No entry is dropped or duplicated.
- Flush has priority over push and pop. The next state is EMPTY and the input offered in the flush cycle is not captured.
- A pop coinciding with flush still counts as completed, so `out_count` increments.
- `out_count` increments on every pop and wraps from 0xFFFF to 0x0000.
- Reset mid-operation behaves exactly like flush, and additionally clears `out_count`.

## Timing
- Latency: instruction accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N when the buffer was EMPTY. Throughput is 1/cycle when `out_ready` is held high.
- `in_ready` is registered: next `in_ready` = (next state != TWO). It is 0 exactly while the state is TWO.
- Reset values: `in_ready`=1, `out_valid`=0, `out_imm`=0, `out_EOp`=0, `out_pc`=0, `out_illegal`=0, `out_count`=0, state EMPTY.
- After flush: `in_ready`=1 and `out_valid`=0 on the following cycle.
- Data outputs hold stable while `out_valid`=1 and `out_ready`=0.
- When state is EMPTY, data outputs hold their last value; downstream ignores them.

## Test plan
- Reset, then a single ori: instr 0x3421_8006, pc 0x3000 -> one cycle later `out_valid`=1, `out_imm`=0x8006, `out_EOp`=01, `out_pc`=0x3000. Raise `out_ready` -> `out_count`=1.
- Opcode sweep with `out_ready` held 1: addiu, andi, lui, beq, R-type 0x0000_0020, opcode 0x3F. Required EOp sequence 00,01,10,11,00,00. Only the last entry has illegal=1. The R-type entry has imm=0x0000.
- Backpressure: `out_ready`=0, push three instructions A,B,C -> `in_ready` drops after B. C is held off until the next pop. Release `out_ready` -> outputs A,B,C in order, `out_count`=3.
- Simultaneous push/pop in ONE with `out_ready`=1 and continuous `in_valid` over 8 instructions -> `in_ready` stays 1, one output per cycle, `out_count`=8.
- Flush while TWO with `in_valid`=1 and `out_ready`=1 -> head counted (`out_count`+1). Next cycle `out_valid`=0 and `in_ready`=1. The offered instruction never appears on the outputs.
- Preload `out_count` to 0xFFFF via 65535 pops, then one more pop -> `out_count`=0x0000. Drive `reset`=0 mid-stream -> all reset values on the next cycle.
